// File: rtl/ibex_lsu_resp_ctrl_pkg.sv
// Shared types for the LSU response controller: writeback instruction type, the per-instruction
// response descriptor, the head beat state and the byte-parity helper.
package ibex_lsu_resp_ctrl_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

  typedef enum logic {
    LSU_BEAT_FIRST  = 1'b0,
    LSU_BEAT_SECOND = 1'b1
  } lsu_beat_e;

  typedef struct packed {
    wb_instr_type_e instr_type;
    logic [1:0]     size;
    logic           sign_ext;
    logic [1:0]     offset;
    logic           split;
  } lsu_resp_desc_t;

  // Even parity per byte: the parity bit makes the byte plus bit carry an even number of ones.
  function automatic logic [3:0] calc_byte_par(logic [31:0] data);
    logic [3:0] par;
    for (int i = 0; i < 4; i++) begin
      par[i] = ^data[8*i +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Combinational load-data alignment: shifts the (possibly two-beat) raw data by the byte offset
// and zero/sign-extends the selected byte, halfword or word.
module ibex_lsu_rdata_align (
  input  logic [63:0] raw_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  output logic [31:0] data_o
);

  logic [63:0] shifted;

  assign shifted = raw_i >> {offset_i, 3'b000};

  // Select the access width and fill the upper bits.
  always_comb begin
    data_o = shifted[31:0];
    case (size_i)
      2'b00:   data_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
      2'b01:   data_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/ibex_lsu_resp_ctrl.sv
// LSU response controller: in-order descriptor FIFO, two-beat merge FSM and writeback response.
// Optional byte-parity checking of load data is enabled by defining IBEX_LSU_RESP_PARITY_EN.
module ibex_lsu_resp_ctrl
  import ibex_lsu_resp_ctrl_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter bit          ResetAll = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_type_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sign_ext_i,
  input  logic [1:0]  req_offset_i,
  input  logic        req_split_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  input  logic [3:0]  data_rpar_i,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o,
  output logic        rf_we_lsu_o,
  output logic [31:0] rf_wdata_lsu_o,
  output logic [1:0]  outstanding_o,
  output logic        busy_o,
  output logic        spurious_resp_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  lsu_resp_desc_t fifo_q [Depth];
  lsu_resp_desc_t req_desc;
  lsu_resp_desc_t head;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  lsu_beat_e       beat_q, beat_d;
  logic [31:0]     hold_data_q;
  logic            hold_err_q;

  logic        empty, push, pop, beat_rvalid, hold_en, head_final;
  logic        par_err, beat_err;
  logic [63:0] raw_data;
  logic [31:0] aligned_data;

  assign req_desc = '{instr_type: wb_instr_type_e'(req_type_i), size: req_size_i,
                      sign_ext: req_sign_ext_i, offset: req_offset_i, split: req_split_i};

  assign empty       = (count_q == {CntW{1'b0}});
  assign req_ready_o = (count_q < CntW'(Depth));
  assign push        = req_valid_i & req_ready_o;
  assign head        = fifo_q[rd_ptr_q];
  assign beat_rvalid = data_rvalid_i & ~empty;
  assign head_final  = (beat_q == LSU_BEAT_SECOND) | ~head.split;
  assign pop         = beat_rvalid & head_final;
  assign hold_en     = beat_rvalid & (beat_q == LSU_BEAT_FIRST) & head.split;

`ifdef IBEX_LSU_RESP_PARITY_EN
  assign par_err = (head.instr_type == WB_INSTR_LOAD) &
                   (calc_byte_par(data_rdata_i) != data_rpar_i);
`else
  logic unused_rpar;
  assign unused_rpar = ^data_rpar_i;
  assign par_err     = 1'b0;
`endif

  assign beat_err = data_err_i | par_err;

  // Pointer, occupancy and held-error state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= {PtrW{1'b0}};
      rd_ptr_q   <= {PtrW{1'b0}};
      count_q    <= {CntW{1'b0}};
      hold_err_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (hold_en) begin
        hold_err_q <= beat_err;
      end
    end
  end

  // Descriptor and first-beat data storage only reset when ResetAll is set.
  if (ResetAll) begin : g_store_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(Depth); i++) begin
          fifo_q[i] <= '0;
        end
        hold_data_q <= 32'h0000_0000;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q] <= req_desc;
        end
        if (hold_en) begin
          hold_data_q <= data_rdata_i;
        end
      end
    end
  end else begin : g_store_norst
    always_ff @(posedge clk_i) begin
      if (push) begin
        fifo_q[wr_ptr_q] <= req_desc;
      end
      if (hold_en) begin
        hold_data_q <= data_rdata_i;
      end
    end
  end

  // Head beat state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q <= LSU_BEAT_FIRST;
    end else begin
      beat_q <= beat_d;
    end
  end

  // Head beat next-state logic.
  always_comb begin
    beat_d = beat_q;
    case (beat_q)
      LSU_BEAT_FIRST: begin
        if (beat_rvalid & head.split) begin
          beat_d = LSU_BEAT_SECOND;
        end else begin
          beat_d = LSU_BEAT_FIRST;
        end
      end
      LSU_BEAT_SECOND: begin
        if (beat_rvalid) begin
          beat_d = LSU_BEAT_FIRST;
        end else begin
          beat_d = LSU_BEAT_SECOND;
        end
      end
      default: beat_d = LSU_BEAT_FIRST;
    endcase
  end

  assign raw_data = (beat_q == LSU_BEAT_SECOND) ? {data_rdata_i, hold_data_q}
                                                : {32'h0000_0000, data_rdata_i};

  ibex_lsu_rdata_align u_rdata_align (
    .raw_i      (raw_data),
    .offset_i   (head.offset),
    .size_i     (head.size),
    .sign_ext_i (head.sign_ext),
    .data_o     (aligned_data)
  );

  assign lsu_resp_valid_o = pop;
  assign lsu_resp_err_o   = pop & (beat_err | ((beat_q == LSU_BEAT_SECOND) & hold_err_q));
  assign rf_we_lsu_o      = lsu_resp_valid_o & (head.instr_type == WB_INSTR_LOAD) & ~lsu_resp_err_o;
  assign rf_wdata_lsu_o   = rf_we_lsu_o ? aligned_data : 32'h0000_0000;
  assign busy_o           = ~empty;
  assign spurious_resp_o  = data_rvalid_i & empty;

  // Beats still expected for the head instruction.
  always_comb begin
    outstanding_o = 2'd0;
    if (empty) begin
      outstanding_o = 2'd0;
    end else if (head.split & (beat_q == LSU_BEAT_FIRST)) begin
      outstanding_o = 2'd2;
    end else begin
      outstanding_o = 2'd1;
    end
  end

endmodule
